layer_mixer: RTL and testbench
==============================

LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 Parameter N_LAYERS, default 4: sprite layer count, range 2-8; layer 0 is the player sprite and has the highest priority.
REQ-002 Parameter COLOR_W, default 12: pixel colour width (4:4:4 RGB).
REQ-003 Parameter KEY_COLOR, default 12'hF0F: transparent colour key.
REQ-004 clk  in  1  system clock; the single clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pixel_tick  in  1  pixel enable, one clk wide; all pipeline stages advance only on this.
REQ-007 video_on  in  1  active display area flag for the current pixel.
REQ-008 frame_start  in  1  one-clk pulse at the first pixel of a frame.
REQ-009 bg_rgb  in  COLOR_W  background colour.
REQ-010 layer_on  in  N_LAYERS  per-layer in-bounds flag for the current pixel.
REQ-011 layer_rgb  in  N_LAYERS*COLOR_W  per-layer colour; layer k occupies bits [k*COLOR_W +: COLOR_W].
REQ-012 layer_en  in  N_LAYERS  requested layer enable mask.
REQ-013 key_en  in  1  1 enables colour-key transparency.
REQ-014 overlay_on, overlay_en  in  1 each  overlay in-bounds flag and overlay enable (game-over screen).
REQ-015 overlay_rgb  in  COLOR_W  overlay colour; never keyed.
REQ-016 rgb  out  COLOR_W  composited pixel for the VGA DAC.
REQ-017 collide_mask  out  N_LAYERS  previous-frame collision result; bit k set means layer 0 overlapped layer k; bit 0 is always 0.
REQ-018 collision_irq  out  1  one-clk pulse on a frame boundary when the captured mask is non-zero.

Function
REQ-019 Layer k counts as opaque when all of the following hold: layer_on[k]=1, shadow enable bit k=1, and NOT (key_en=1 and layer_rgb[k]=KEY_COLOR).
REQ-020 Shadow enable register: loaded from layer_en on the clk where frame_start=1; it holds its value for the whole frame, so mid-frame layer_en changes are ignored.
REQ-021 Pipeline stage 1, on pixel_tick: register video_on, overlay_on AND overlay_en, overlay_rgb, bg_rgb, the opaque vector and all layer colours.
REQ-022 Pipeline stage 2, on pixel_tick, first match wins:
  - stage-1 video_on=0: black (0);
  - overlay active: overlay_rgb;
  - otherwise the lowest-index opaque layer;
  - otherwise bg_rgb.
REQ-023 Latency: rgb reflects the inputs sampled at pixel_tick n on the clk after pixel_tick n+1 (2 pixel ticks); rgb holds between ticks.
REQ-024 Hit accumulator, on pixel_tick with stage-1 video_on=1 and opaque[0]=1: OR opaque[k] into acc[k] for k>=1. acc[0] is always 0. Overlay has no effect on hit detection.
REQ-025 On the frame_start clk:
  - collide_mask <= acc, including any hit from a pixel_tick in that same clk;
  - acc cleared;
  - collision_irq=1 on the next clk when the loaded mask is non-zero, and 0 otherwise.
REQ-026 frame_start coincident with pixel_tick: the pipeline advances normally, and the new shadow enable applies from the next sampled pixel.
REQ-027 Back-to-back frame_start pulses: a mask of all zeros is captured the second time, with no irq.
REQ-028 Stages do not advance without pixel_tick; pixel_tick held high advances every clk.

Reset
REQ-029 While reset=1, and immediately on assertion, regardless of clk:
  - rgb, collide_mask, acc and collision_irq = 0;
  - all pipeline registers = 0;
  - shadow enable = all ones.
REQ-030 Reset during a frame discards in-flight pixels and accumulated hits; the first post-reset frame_start captures only hits seen after reset.

Verification
REQ-031 Priority: shadow all ones, layer_on=4'b0110, colours L1=12'h00F and L2=12'h0F0, key_en=0 -> rgb=12'h00F two ticks later.
REQ-032 Colour key: layer_on=4'b0011, L0=12'hF0F, L1=12'h123, key_en=1 -> rgb=12'h123; same stimulus with key_en=0 -> rgb=12'hF0F.
REQ-033 Overlay and blanking:
  - overlay_on=overlay_en=1, overlay_rgb=12'hFFF, L0 opaque -> 12'hFFF;
  - video_on=0 with the same inputs -> 12'h000.
REQ-034 Collision capture:
  - one tick with L0 and L3 opaque, then frame_start -> collide_mask=4'b1000 and irq pulses once;
  - next frame with no overlap, then frame_start -> mask 0, no irq.
REQ-035 Enable shadowing: layer_en changed to 4'b1101 mid-frame -> layer 1 is still shown until the next frame_start, then replaced by bg_rgb.
REQ-036 Async reset: assert reset between clk edges mid-frame -> rgb=0 and collide_mask=0 immediately; the pipeline refills after two pixel ticks.

Source files
------------

// File: rtl/layer_mixer.sv
// layer_mixer: two-stage sprite compositor with colour key, overlay and per-frame collision capture.
// Rev 1.0
`default_nettype none

module layer_mixer #(
  parameter int                 N_LAYERS  = 4,
  parameter int                 COLOR_W   = 12,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pixel_tick,
  input  logic                         video_on,
  input  logic                         frame_start,
  input  logic [COLOR_W-1:0]           bg_rgb,
  input  logic [N_LAYERS-1:0]          layer_on,
  input  logic [N_LAYERS*COLOR_W-1:0]  layer_rgb,
  input  logic [N_LAYERS-1:0]          layer_en,
  input  logic                         key_en,
  input  logic                         overlay_on,
  input  logic                         overlay_en,
  input  logic [COLOR_W-1:0]           overlay_rgb,
  output logic [COLOR_W-1:0]           rgb,
  output logic [N_LAYERS-1:0]          collide_mask,
  output logic                         collision_irq
);

  logic [N_LAYERS-1:0]         shadow_q;
  logic [N_LAYERS-1:0]         opaque;
  logic                        s1_video_q;
  logic                        s1_ovl_q;
  logic [COLOR_W-1:0]          s1_ovl_rgb_q;
  logic [COLOR_W-1:0]          s1_bg_q;
  logic [N_LAYERS-1:0]         s1_opaque_q;
  logic [N_LAYERS*COLOR_W-1:0] s1_layer_q;
  logic [COLOR_W-1:0]          rgb_q;
  logic [COLOR_W-1:0]          rgb_d;
  logic [N_LAYERS-1:0]         acc_q;
  logic [N_LAYERS-1:0]         acc_d;
  logic [N_LAYERS-1:0]         mask_q;
  logic                        irq_q;
  logic                        hit;

  // Opacity uses the frame-latched enable, so mid-frame layer_en edits are ignored.
  always_comb begin
    opaque = '0;
    for (int k = 0; k < N_LAYERS; k++) begin
      opaque[k] = layer_on[k] & shadow_q[k] &
                  ~(key_en & (layer_rgb[k*COLOR_W +: COLOR_W] == KEY_COLOR));
    end
  end

  // Later assignments override earlier ones, giving blank > overlay > lowest layer > background.
  always_comb begin
    rgb_d = s1_bg_q;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (s1_opaque_q[k]) rgb_d = s1_layer_q[k*COLOR_W +: COLOR_W];
    end
    if (s1_ovl_q)    rgb_d = s1_ovl_rgb_q;
    if (!s1_video_q) rgb_d = '0;
  end

  // A hit lands in the same clk as the pixel reaches stage 2, so frame_start can capture it.
  assign hit   = pixel_tick & s1_video_q & s1_opaque_q[0];
  assign acc_d = acc_q | (hit ? {s1_opaque_q[N_LAYERS-1:1], 1'b0} : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= '1;
      s1_video_q   <= 1'b0;
      s1_ovl_q     <= 1'b0;
      s1_ovl_rgb_q <= '0;
      s1_bg_q      <= '0;
      s1_opaque_q  <= '0;
      s1_layer_q   <= '0;
      rgb_q        <= '0;
      acc_q        <= '0;
      mask_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (frame_start) shadow_q <= layer_en;
      if (pixel_tick) begin
        s1_video_q   <= video_on;
        s1_ovl_q     <= overlay_on & overlay_en;
        s1_ovl_rgb_q <= overlay_rgb;
        s1_bg_q      <= bg_rgb;
        s1_opaque_q  <= opaque;
        s1_layer_q   <= layer_rgb;
        rgb_q        <= rgb_d;
      end
      if (frame_start) begin
        mask_q <= acc_d;
        acc_q  <= '0;
        irq_q  <= |acc_d;
      end else begin
        acc_q  <= acc_d;
        irq_q  <= 1'b0;
      end
    end
  end

  assign rgb           = rgb_q;
  assign collide_mask  = mask_q;
  assign collision_irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_layer_mixer.sv
// tb_layer_mixer: directed and randomized checks of layer_mixer against a sample-then-delay reference model.
`default_nettype none

module tb_layer_mixer;

  localparam int N  = 4;
  localparam int CW = 12;
  localparam logic [CW-1:0] KEY = 12'hF0F;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            pixel_tick = 1'b0;
  logic            video_on = 1'b0;
  logic            frame_start = 1'b0;
  logic [CW-1:0]   bg_rgb = '0;
  logic [N-1:0]    layer_on = '0;
  logic [N*CW-1:0] layer_rgb = '0;
  logic [N-1:0]    layer_en = '1;
  logic            key_en = 1'b0;
  logic            overlay_on = 1'b0;
  logic            overlay_en = 1'b0;
  logic [CW-1:0]   overlay_rgb = '0;
  logic [CW-1:0]   rgb;
  logic [N-1:0]    collide_mask;
  logic            collision_irq;

  int checks = 0;
  int errors = 0;

  // Reference model: compose each pixel when sampled, show it one tick later.
  logic [N-1:0]  m_shadow;
  logic [CW-1:0] m_pend_rgb, m_rgb;
  logic [N-1:0]  m_pend_hit, m_acc, m_mask;
  logic          m_irq;

  layer_mixer #(.N_LAYERS(N), .COLOR_W(CW), .KEY_COLOR(KEY)) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .frame_start(frame_start), .bg_rgb(bg_rgb), .layer_on(layer_on),
    .layer_rgb(layer_rgb), .layer_en(layer_en), .key_en(key_en),
    .overlay_on(overlay_on), .overlay_en(overlay_en), .overlay_rgb(overlay_rgb),
    .rgb(rgb), .collide_mask(collide_mask), .collision_irq(collision_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] opq(input logic [N-1:0] sh);
    logic [N-1:0] o;
    for (int k = 0; k < N; k++)
      o[k] = layer_on[k] && sh[k] && !(key_en && layer_rgb[k*CW +: CW] == KEY);
    return o;
  endfunction

  function automatic logic [CW-1:0] compose(input logic [N-1:0] sh);
    logic [N-1:0] o;
    o = opq(sh);
    if (!video_on) return '0;
    if (overlay_on && overlay_en) return overlay_rgb;
    for (int k = 0; k < N; k++) if (o[k]) return layer_rgb[k*CW +: CW];
    return bg_rgb;
  endfunction

  function automatic logic [N-1:0] hitvec(input logic [N-1:0] sh);
    logic [N-1:0] o;
    o = opq(sh);
    return (video_on && o[0]) ? {o[N-1:1], 1'b0} : '0;
  endfunction

  task automatic model_reset();
    m_shadow = '1; m_pend_rgb = '0; m_rgb = '0;
    m_pend_hit = '0; m_acc = '0; m_mask = '0; m_irq = 1'b0;
  endtask

  task automatic set_layer(input int k, input logic [CW-1:0] c);
    layer_rgb[k*CW +: CW] = c;
  endtask

  task automatic clk_step(input logic tick, input logic fs);
    logic [CW-1:0] cur;
    logic [N-1:0]  curhit, tot;
    pixel_tick = tick; frame_start = fs;
    @(posedge clk);
    cur = compose(m_shadow); curhit = hitvec(m_shadow);
    tot = m_acc | (tick ? m_pend_hit : '0);
    if (tick) begin m_rgb = m_pend_rgb; m_pend_rgb = cur; m_pend_hit = curhit; end
    if (fs) begin m_mask = tot; m_irq = |tot; m_acc = '0; m_shadow = layer_en; end
    else begin m_acc = tot; m_irq = 1'b0; end
    #1; pixel_tick = 1'b0; frame_start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (rgb !== '0) begin errors++; $display("FAIL reset_rgb got=%h exp=%h", rgb, 12'h000); end
    checks++; if (collide_mask !== '0) begin errors++; $display("FAIL reset_mask got=%b exp=%b", collide_mask, 4'b0000); end
    checks++; if (collision_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", collision_irq); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_priority();
    video_on = 1; layer_on = 4'b0110; bg_rgb = 12'h555; key_en = 0;
    set_layer(0, 12'h000); set_layer(1, 12'h00F); set_layer(2, 12'h0F0); set_layer(3, 12'h000);
    clk_step(1, 0); clk_step(1, 0);
    checks++; if (rgb !== 12'h00F) begin errors++; $display("FAIL priority got=%h exp=%h", rgb, 12'h00F); end
  endtask

  task automatic test_key();
    layer_on = 4'b0011; set_layer(0, 12'hF0F); set_layer(1, 12'h123); key_en = 1;
    clk_step(1, 0); clk_step(1, 0);
    checks++; if (rgb !== 12'h123) begin errors++; $display("FAIL key_on got=%h exp=%h", rgb, 12'h123); end
    key_en = 0;
    clk_step(1, 0); clk_step(1, 0);
    checks++; if (rgb !== 12'hF0F) begin errors++; $display("FAIL key_off got=%h exp=%h", rgb, 12'hF0F); end
    // No tick: output must hold.
    set_layer(0, 12'h777); clk_step(0, 0); clk_step(0, 0);
    checks++; if (rgb !== 12'hF0F) begin errors++; $display("FAIL hold got=%h exp=%h", rgb, 12'hF0F); end
  endtask

  task automatic test_overlay();
    overlay_on = 1; overlay_en = 1; overlay_rgb = 12'hFFF; layer_on = 4'b0001; set_layer(0, 12'hF0F);
    clk_step(1, 0); clk_step(1, 0);
    checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL overlay got=%h exp=%h", rgb, 12'hFFF); end
    video_on = 0;
    clk_step(1, 0); clk_step(1, 0);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank got=%h exp=%h", rgb, 12'h000); end
    overlay_on = 0; overlay_en = 0;
  endtask

  task automatic test_collision();
    clk_step(1, 0); clk_step(1, 0); clk_step(0, 1);
    video_on = 1; layer_on = 4'b1001; set_layer(0, 12'h111); set_layer(3, 12'h333);
    clk_step(1, 0);
    video_on = 0; layer_on = 4'b0000;
    clk_step(1, 0); clk_step(0, 1);
    checks++; if (collide_mask !== 4'b1000) begin errors++; $display("FAIL coll_mask got=%b exp=%b", collide_mask, 4'b1000); end
    checks++; if (collision_irq !== 1'b1) begin errors++; $display("FAIL coll_irq got=%b exp=1", collision_irq); end
    clk_step(0, 0);
    checks++; if (collision_irq !== 1'b0) begin errors++; $display("FAIL coll_irq_pulse got=%b exp=0", collision_irq); end
    video_on = 1; layer_on = 4'b0001;
    clk_step(1, 0); clk_step(1, 0); video_on = 0; clk_step(1, 0); clk_step(0, 1);
    checks++; if (collide_mask !== 4'b0000) begin errors++; $display("FAIL nocoll_mask got=%b exp=%b", collide_mask, 4'b0000); end
    checks++; if (collision_irq !== 1'b0) begin errors++; $display("FAIL nocoll_irq got=%b exp=0", collision_irq); end
    clk_step(0, 1);
    checks++; if (collide_mask !== 4'b0000 || collision_irq !== 1'b0) begin
      errors++; $display("FAIL back_to_back got=%b/%b exp=0000/0", collide_mask, collision_irq); end
  endtask

  task automatic test_shadow();
    video_on = 1; layer_on = 4'b0010; set_layer(1, 12'h0AB); bg_rgb = 12'h555;
    clk_step(1, 0); clk_step(1, 0);
    checks++; if (rgb !== 12'h0AB) begin errors++; $display("FAIL shadow_pre got=%h exp=%h", rgb, 12'h0AB); end
    layer_en = 4'b1101;
    clk_step(1, 0); clk_step(1, 0);
    checks++; if (rgb !== 12'h0AB) begin errors++; $display("FAIL shadow_mid got=%h exp=%h", rgb, 12'h0AB); end
    clk_step(0, 1); clk_step(1, 0); clk_step(1, 0);
    checks++; if (rgb !== 12'h555) begin errors++; $display("FAIL shadow_new got=%h exp=%h", rgb, 12'h555); end
    layer_en = 4'b1111; clk_step(0, 1);
  endtask

  task automatic test_async_reset();
    video_on = 1; layer_on = 4'b0101; set_layer(0, 12'h111); set_layer(2, 12'h222);
    clk_step(1, 0); clk_step(1, 0); clk_step(0, 1); clk_step(1, 0);
    checks++; if (collide_mask !== 4'b0100) begin errors++; $display("FAIL pre_reset_mask got=%b exp=%b", collide_mask, 4'b0100); end
    #2 reset = 1'b1;
    #1;
    checks++; if (rgb !== '0 || collide_mask !== '0 || collision_irq !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%h/%b/%b exp=000/0000/0", rgb, collide_mask, collision_irq); end
    #3 reset = 1'b0;
    model_reset();
    layer_on = 4'b0010; set_layer(1, 12'h0AB);
    clk_step(1, 0);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL refill1 got=%h exp=%h", rgb, 12'h000); end
    clk_step(1, 0);
    checks++; if (rgb !== 12'h0AB) begin errors++; $display("FAIL refill2 got=%h exp=%h", rgb, 12'h0AB); end
    clk_step(1, 0); clk_step(0, 1);
    checks++; if (collide_mask !== 4'b0000 || collision_irq !== 1'b0) begin
      errors++; $display("FAIL post_reset_capture got=%b/%b exp=0000/0", collide_mask, collision_irq); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      video_on    = ($urandom_range(0, 7) != 0);
      layer_on    = N'($urandom());
      if ($urandom_range(0, 1) == 1) layer_on[0] = 1'b1;
      for (int k = 0; k < N; k++) set_layer(k, ($urandom_range(0, 3) == 0) ? KEY : CW'($urandom()));
      bg_rgb      = CW'($urandom());
      key_en      = 1'($urandom());
      overlay_on  = ($urandom_range(0, 5) == 0);
      overlay_en  = 1'($urandom());
      overlay_rgb = CW'($urandom());
      if ($urandom_range(0, 15) == 0) layer_en = N'($urandom());
      clk_step(($urandom_range(0, 9) < 6), ($urandom_range(0, 24) == 0));
      checks++; if (rgb !== m_rgb) begin errors++; $display("FAIL rand_rgb cyc=%0d got=%h exp=%h", i, rgb, m_rgb); end
      checks++; if (collide_mask !== m_mask) begin errors++; $display("FAIL rand_mask cyc=%0d got=%b exp=%b", i, collide_mask, m_mask); end
      checks++; if (collision_irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, collision_irq, m_irq); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_key();
    test_overlay();
    test_collision();
    test_shadow();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
